// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and helpers shared by the CPU front-end blocks.
//   CPU_ADDR_W       default PC / target width
//   ctr_weak_taken   weakly-taken encoding of a w-bit saturating counter
//   ctr_weak_ntaken  weakly-not-taken encoding of a w-bit saturating counter
package cpu_pkg;

    localparam int CPU_ADDR_W = 32;

    // The counter MSB is the prediction, so the two "weak" states sit on
    // either side of the midpoint.
    function automatic int unsigned ctr_weak_taken(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned ctr_weak_ntaken(input int unsigned w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// sat_counter: next-value logic for a CTR_W-bit saturating up/down counter.
// Ports:
//   ctr       current counter value
//   inc       1 = count up, 0 = count down
//   next_ctr  next value, held at all-ones when counting up and at zero
//             when counting down
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             inc,
    output logic [CTR_W-1:0] next_ctr
);

    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};

    function automatic logic [CTR_W-1:0] sat_step(input logic [CTR_W-1:0] v,
                                                  input logic up);
        if (up)
            return (v == CTR_MAX) ? v : v + CTR_W'(1);
        else
            return (v == '0) ? v : v - CTR_W'(1);
    endfunction

    assign next_ctr = sat_step(ctr, inc);

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped branch target buffer with per-entry
// saturating direction counters.
//   Lookup (IF stage) is combinational: predict_hit_o / predict_taken_o /
//   predict_target_o follow lookup_pc_i in the same cycle.
//   Update (ID stage) is applied at the rising edge of clk_i when
//   update_valid_i is high; mispredict_o flags the resolving branch
//   combinationally. invalidate_all_i drops every entry and wins over an
//   update in the same cycle. rst_i is asynchronous, active-low.
// Ports:
//   clk_i, rst_i                         clock, async active-low reset
//   lookup_pc_i                          PC being fetched
//   predict_hit_o/taken_o/target_o       prediction for lookup_pc_i
//   update_valid_i/pc_i/taken_i/target_i resolved branch
//   update_pred_taken_i/pred_target_i    prediction that branch was fetched with
//   invalidate_all_i                     clear the whole table
//   mispredict_o                         resolved branch was mispredicted
//   stat_updates_o, stat_mispred_o       statistics counters
// Build option: define BRANCH_PREDICTOR_STATS_EN to implement the statistics
// counters; otherwise both stat ports are tied to zero.
module branch_predictor
    import cpu_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int CTR_W   = 2,
    parameter int ADDR_W  = CPU_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] lookup_pc_i,
    output logic              predict_hit_o,
    output logic              predict_taken_o,
    output logic [ADDR_W-1:0] predict_target_o,
    input  logic              update_valid_i,
    input  logic [ADDR_W-1:0] update_pc_i,
    input  logic              update_taken_i,
    input  logic [ADDR_W-1:0] update_target_i,
    input  logic              update_pred_taken_i,
    input  logic [ADDR_W-1:0] update_pred_target_i,
    input  logic              invalidate_all_i,
    output logic              mispredict_o,
    output logic [31:0]       stat_updates_o,
    output logic [31:0]       stat_mispred_o
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;

    localparam logic [CTR_W-1:0] CTR_WEAK_T  = CTR_W'(ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WEAK_NT = CTR_W'(ctr_weak_ntaken(CTR_W));

    logic [ENTRIES-1:0] valid;
    logic [CTR_W-1:0]   ctrs    [ENTRIES];
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [ADDR_W-1:0]  targets [ENTRIES];

    logic [IDX_W-1:0] lk_idx, up_idx;
    logic [TAG_W-1:0] lk_tag, up_tag;
    logic             up_hit;
    logic [CTR_W-1:0] ctr_next;

    // Instruction-alignment bits never take part in indexing or tagging.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{lookup_pc_i[1:0], update_pc_i[1:0]};

    assign lk_idx = lookup_pc_i[IDX_W+1:2];
    assign lk_tag = lookup_pc_i[ADDR_W-1:IDX_W+2];
    assign up_idx = update_pc_i[IDX_W+1:2];
    assign up_tag = update_pc_i[ADDR_W-1:IDX_W+2];

    // Lookup reads the stored state directly, so an update landing on the
    // same index this cycle is not visible until after the edge.
    assign predict_hit_o    = valid[lk_idx] && (tags[lk_idx] == lk_tag);
    assign predict_taken_o  = predict_hit_o && ctrs[lk_idx][CTR_W-1];
    assign predict_target_o = predict_hit_o ? targets[lk_idx] : '0;

    assign up_hit = valid[up_idx] && (tags[up_idx] == up_tag);

    assign mispredict_o = update_valid_i &&
                          ((update_pred_taken_i != update_taken_i) ||
                           (update_taken_i && (update_pred_target_i != update_target_i)));

    sat_counter #(.CTR_W(CTR_W)) u_sat_counter (
        .ctr      (ctrs[up_idx]),
        .inc      (update_taken_i),
        .next_ctr (ctr_next)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid <= '0;
            for (int i = 0; i < ENTRIES; i++)
                ctrs[i] <= CTR_WEAK_NT;
        end else if (invalidate_all_i) begin
            valid <= '0;
        end else if (update_valid_i) begin
            if (up_hit) begin
                ctrs[up_idx] <= ctr_next;
            end else if (update_taken_i) begin
                valid[up_idx] <= 1'b1;
                ctrs[up_idx]  <= CTR_WEAK_T;
            end
        end
    end

    // A taken update either refreshes a hit entry (same tag) or allocates
    // over whatever aliased there, so tag and target are written together.
    // Nothing written here is visible unless the control block above marks
    // the entry valid, which covers invalidate and reset.
    always_ff @(posedge clk_i) begin
        if (update_valid_i && update_taken_i && !invalidate_all_i) begin
            tags[up_idx]    <= up_tag;
            targets[up_idx] <= update_target_i;
        end
    end

`ifdef BRANCH_PREDICTOR_STATS_EN
    logic [31:0] upd_cnt, mis_cnt;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            upd_cnt <= '0;
            mis_cnt <= '0;
        end else begin
            if (update_valid_i) upd_cnt <= sat_inc32(upd_cnt);
            if (mispredict_o)   mis_cnt <= sat_inc32(mis_cnt);
        end
    end

    assign stat_updates_o = upd_cnt;
    assign stat_mispred_o = mis_cnt;
`else
    assign stat_updates_o = '0;
    assign stat_mispred_o = '0;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and randomized stimulus for branch_predictor
// (ENTRIES=64, CTR_W=2, ADDR_W=32) against a table model kept in plain
// arithmetic. Build option BRANCH_PREDICTOR_STATS_EN selects whether the
// statistics ports are expected to count or to stay at zero.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [31:0] lookup_pc_i;
    logic        predict_hit_o, predict_taken_o;
    logic [31:0] predict_target_o;
    logic        update_valid_i;
    logic [31:0] update_pc_i;
    logic        update_taken_i;
    logic [31:0] update_target_i;
    logic        update_pred_taken_i;
    logic [31:0] update_pred_target_i;
    logic        invalidate_all_i;
    logic        mispredict_o;
    logic [31:0] stat_updates_o, stat_mispred_o;

    int checks = 0;
    int errors = 0;

`ifdef BRANCH_PREDICTOR_STATS_EN
    localparam bit STATS_ON = 1'b1;
`else
    localparam bit STATS_ON = 1'b0;
`endif

    // Reference model: 64 entries, index = (pc/4) mod 64, tag = pc/256,
    // counter kept as an integer 0..3, predict taken when counter >= 2.
    int          m_valid [64];
    int unsigned m_tag   [64];
    int unsigned m_tgt   [64];
    int          m_ctr   [64];
    int unsigned m_upd_cnt, m_mis_cnt;

    branch_predictor dut (
        .clk_i                (clk),
        .rst_i                (rst_i),
        .lookup_pc_i          (lookup_pc_i),
        .predict_hit_o        (predict_hit_o),
        .predict_taken_o      (predict_taken_o),
        .predict_target_o     (predict_target_o),
        .update_valid_i       (update_valid_i),
        .update_pc_i          (update_pc_i),
        .update_taken_i       (update_taken_i),
        .update_target_i      (update_target_i),
        .update_pred_taken_i  (update_pred_taken_i),
        .update_pred_target_i (update_pred_target_i),
        .invalidate_all_i     (invalidate_all_i),
        .mispredict_o         (mispredict_o),
        .stat_updates_o       (stat_updates_o),
        .stat_mispred_o       (stat_mispred_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc >> 2) % 64);
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        int i;
        i = m_idx(pc);
        return (m_valid[i] != 0) && (m_tag[i] == (pc >> 8));
    endfunction

    function automatic logic m_taken(input logic [31:0] pc);
        return m_hit(pc) && (m_ctr[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_target(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[m_idx(pc)] : 32'd0;
    endfunction

    function automatic logic m_mispred();
        if (!update_valid_i) return 1'b0;
        if (update_pred_taken_i != update_taken_i) return 1'b1;
        return update_taken_i && (update_pred_target_i != update_target_i);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_valid[i] = 0;
            m_ctr[i]   = 1;
        end
        m_upd_cnt = 0;
        m_mis_cnt = 0;
    endtask

    task automatic check_lookup(input string tag, input logic [31:0] pc);
        lookup_pc_i = pc;
        #1;
        chk({tag, ".hit"},    predict_hit_o,    m_hit(pc));
        chk({tag, ".taken"},  predict_taken_o,  m_taken(pc));
        chk({tag, ".target"}, predict_target_o, m_target(pc));
    endtask

    task automatic check_stats(input string tag);
        chk({tag, ".updates"}, stat_updates_o, STATS_ON ? m_upd_cnt : 32'd0);
        chk({tag, ".mispred"}, stat_mispred_o, STATS_ON ? m_mis_cnt : 32'd0);
    endtask

    task automatic upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                       input logic ptk, input logic [31:0] ptgt);
        update_valid_i       = 1'b1;
        update_pc_i          = pc;
        update_taken_i       = tk;
        update_target_i      = tgt;
        update_pred_taken_i  = ptk;
        update_pred_target_i = ptgt;
        #1;
        chk("mispredict", mispredict_o, m_mispred());
    endtask

    // Advance one edge, mirror its effect in the model, then drop the
    // one-shot controls.
    task automatic tick();
        int i;
        @(posedge clk);
        if (rst_i) begin
            if (update_valid_i) m_upd_cnt++;
            if (m_mispred())    m_mis_cnt++;
            if (invalidate_all_i) begin
                for (int k = 0; k < 64; k++) m_valid[k] = 0;
            end else if (update_valid_i) begin
                i = m_idx(update_pc_i);
                if (m_hit(update_pc_i)) begin
                    if (update_taken_i) begin
                        m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                        m_tgt[i] = update_target_i;
                    end else begin
                        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
                    end
                end else if (update_taken_i) begin
                    m_valid[i] = 1;
                    m_tag[i]   = update_pc_i >> 8;
                    m_tgt[i]   = update_target_i;
                    m_ctr[i]   = 2;
                end
            end
        end
        #1;
        update_valid_i   = 1'b0;
        invalidate_all_i = 1'b0;
    endtask

    task automatic pulse_reset(input string tag);
        rst_i = 1'b0;
        #1;
        model_reset();
        chk({tag, ".hit"},    predict_hit_o,    1'b0);
        chk({tag, ".taken"},  predict_taken_o,  1'b0);
        chk({tag, ".target"}, predict_target_o, 32'd0);
        check_stats(tag);
        tick();
        #2;
        rst_i = 1'b1;
    endtask

    function automatic logic [31:0] rpc();
        return ($urandom_range(0, 7) << 8) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
    endfunction

    initial begin
        logic [31:0] pc, tgt;
        logic        tk;

        rst_i = 1'b0;
        lookup_pc_i = 32'h100;
        update_valid_i = 1'b0; update_pc_i = '0; update_taken_i = 1'b0;
        update_target_i = '0; update_pred_taken_i = 1'b0; update_pred_target_i = '0;
        invalidate_all_i = 1'b0;
        model_reset();

        // Reset state and release
        #1;
        chk("rst.hit", predict_hit_o, 1'b0);
        chk("rst.taken", predict_taken_o, 1'b0);
        chk("rst.target", predict_target_o, 32'd0);
        check_stats("rst");
        @(posedge clk); #3;
        rst_i = 1'b1;
        check_lookup("release", 32'h100);

        // Allocate 0x100 -> 0x80
        upd(32'h100, 1'b1, 32'h80, 1'b0, 32'h0);
        tick();
        check_lookup("alloc", 32'h100);
        chk("alloc.taken_lit", predict_taken_o, 1'b1);
        chk("alloc.target_lit", predict_target_o, 32'h80);

        // Three not-taken: counter 2 -> 1 -> 0 -> 0
        for (int k = 0; k < 3; k++) begin
            upd(32'h100, 1'b0, 32'h80, m_taken(32'h100), m_target(32'h100));
            tick();
            check_lookup("nt", 32'h100);
        end
        chk("nt.taken_lit", predict_taken_o, 1'b0);

        // Two taken with fresh targets: counter 0 -> 1 -> 2
        upd(32'h100, 1'b1, 32'h90, 1'b0, 32'h80);
        tick();
        check_lookup("tk1", 32'h100);
        upd(32'h100, 1'b1, 32'hA0, 1'b0, 32'h90);
        tick();
        check_lookup("tk2", 32'h100);
        chk("tk2.taken_lit", predict_taken_o, 1'b1);
        chk("tk2.target_lit", predict_target_o, 32'hA0);

        // Update and lookup on one index in one cycle: old contents seen
        upd(32'h100, 1'b0, 32'h0, 1'b1, 32'hA0);
        check_lookup("nobypass.pre", 32'h100);
        chk("nobypass.pre_lit", predict_taken_o, 1'b1);
        tick();
        check_lookup("nobypass.post", 32'h100);

        // Aliasing allocate at 0x200 replaces 0x100
        upd(32'h200, 1'b1, 32'h44, 1'b0, 32'h0);
        tick();
        check_lookup("alias.old", 32'h100);
        check_lookup("alias.new", 32'h200);

        // Not-taken miss leaves table alone
        upd(32'h400, 1'b0, 32'h55, 1'b0, 32'h0);
        tick();
        check_lookup("ntmiss.new", 32'h400);
        check_lookup("ntmiss.keep", 32'h200);

        // Invalidate beats a simultaneous taken update
        upd(32'h300, 1'b1, 32'h66, 1'b0, 32'h0);
        invalidate_all_i = 1'b1;
        tick();
        check_lookup("inval.100", 32'h100);
        check_lookup("inval.300", 32'h300);
        check_lookup("inval.200", 32'h200);
        check_stats("inval");

        // Statistics: three updates, one mispredicted
        pulse_reset("srst");
        upd(32'h110, 1'b1, 32'h10, 1'b1, 32'h10);
        tick();
        upd(32'h114, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        upd(32'h118, 1'b0, 32'h0, 1'b1, 32'h20);
        chk("stat.pulse", mispredict_o, 1'b1);
        tick();
        #1;
        check_stats("stat3");
        chk("stat3.upd_lit", stat_updates_o, STATS_ON ? 32'd3 : 32'd0);
        chk("stat3.mis_lit", stat_mispred_o, STATS_ON ? 32'd1 : 32'd0);

        // Reset asserted during an in-flight update abandons it
        upd(32'h500, 1'b1, 32'h77, 1'b0, 32'h0);
        pulse_reset("abandon");
        check_lookup("abandon", 32'h500);
        check_lookup("abandon.110", 32'h110);
        check_stats("abandon");

        // Randomized traffic over a small PC pool (8 tags x 4 indices)
        for (int n = 0; n < 400; n++) begin
            check_lookup("rnd.lk", rpc());
            pc  = rpc();
            tk  = 1'($urandom_range(0, 1));
            tgt = $urandom_range(0, 3) << 4;
            if ($urandom_range(0, 1) != 0)
                upd(pc, tk, tgt, m_taken(pc), m_target(pc));
            else
                upd(pc, tk, tgt, 1'($urandom_range(0, 1)), $urandom_range(0, 3) << 4);
            if ($urandom_range(0, 9) == 0) update_valid_i = 1'b0;
            if ($urandom_range(0, 39) == 0) invalidate_all_i = 1'b1;
            tick();
        end
        #1;
        check_stats("rnd.end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
